cacheline_arbiter: RTL and testbench

Two-requester arbiter that merges the instruction-cache and data-cache miss ports onto the single 256-bit `dfp_*` cacheline port of the burst adapter. The adapter fills or writes back one 32-byte line per transaction. This block selects one requester at a time, latches its request, and holds it stable on `dfp_*` until `dfp_resp`. It then routes `dfp_rdata` and the response back to the granted requester.

---
 rtl/cacheline_arbiter_pkg.sv | 36 +++
 rtl/rr_pick2.sv | 23 ++
 rtl/cacheline_arbiter.sv | 118 +++++++++++
 tb/tb_cacheline_arbiter.sv | 427 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cacheline_arbiter_pkg.sv
// cache_arb_pkg: shared widths, FSM encoding and the latched request record
// used by the cacheline arbiter.
//   LINE_W      : cacheline width in bits (one 32-byte line)
//   ADDR_W      : line address width
//   arb_state_t : arbiter FSM states
//   line_req_t  : one latched line request as presented on dfp_*
//   make_req    : builds a line_req_t; a write always beats a read
package cache_arb_pkg;

  localparam int LINE_W = 256;
  localparam int ADDR_W = 32;

  typedef enum logic [1:0] {ARB_IDLE, ARB_GNT0, ARB_GNT1} arb_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] wdata;
    logic              read;
    logic              write;
  } line_req_t;

  // A requester asserting both read and write is illegal; the write is kept
  // so a dirty line is never silently lost.
  function automatic line_req_t make_req(input logic [ADDR_W-1:0] addr,
                                         input logic [LINE_W-1:0] wdata,
                                         input logic              read,
                                         input logic              write);
    line_req_t r;
    r.addr  = addr;
    r.wdata = wdata;
    r.read  = read & ~write;
    r.write = write;
    return r;
  endfunction

endpackage

// File: rtl/rr_pick2.sv
// rr_pick2: combinational two-way picker.
//   req   : request vector, bit N = port N requesting
//   last  : port that won the previous completed grant
//   fixed : 1 = port 1 wins every tie, 0 = the port not in 'last' wins
//   gnt   : one-hot grant (all zero when nobody requests)
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  input  logic       fixed,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (fixed || !last) ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/cacheline_arbiter.sv
// cacheline_arbiter: merges the icache (port 0) and dcache (port 1) line-miss
// ports onto the single dfp_* cacheline port of the burst adapter.
//
// Handshake: a requester raises pN_read or pN_write (with addr/wdata) and
// holds it unchanged-in-kind until the single-cycle pN_resp; it drops the
// request in the cycle after pN_resp. On dfp_*, dfp_read/dfp_write stay high
// from the grant through the dfp_resp cycle; dfp_resp completes the
// transaction and is ignored while no grant is outstanding.
//
// Ports:
//   clk, rst_n               : clock, asynchronous active-low reset
//   pN_addr/read/write/wdata : requester N line request
//   pN_rdata, pN_resp        : completion back to requester N (zero when not
//                              the granted, completing port)
//   dfp_addr/read/write/wdata: latched request of the granted port
//   dfp_rdata, dfp_resp      : completion from the adapter
//   dbg_state                : current FSM state, for observation only
module cacheline_arbiter
  import cache_arb_pkg::*;
#(
  parameter int FIXED_PRIO = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic              p0_read,
  input  logic              p0_write,
  input  logic [LINE_W-1:0] p0_wdata,
  output logic [LINE_W-1:0] p0_rdata,
  output logic              p0_resp,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic              p1_read,
  input  logic              p1_write,
  input  logic [LINE_W-1:0] p1_wdata,
  output logic [LINE_W-1:0] p1_rdata,
  output logic              p1_resp,
  output logic [ADDR_W-1:0] dfp_addr,
  output logic              dfp_read,
  output logic              dfp_write,
  output logic [LINE_W-1:0] dfp_wdata,
  input  logic [LINE_W-1:0] dfp_rdata,
  input  logic              dfp_resp,
  output arb_state_t        dbg_state
);

  arb_state_t state;
  logic       last_gnt;   // 1 after reset so port 0 takes the first tie
  line_req_t  req_q;
  logic [1:0] req_vec;
  logic [1:0] gnt;

  assign req_vec = {p1_read | p1_write, p0_read | p0_write};

  rr_pick2 u_pick (
    .req   (req_vec),
    .last  (last_gnt),
    .fixed (FIXED_PRIO != 0),
    .gnt   (gnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ARB_IDLE;
      last_gnt <= 1'b1;
      req_q    <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (gnt[0]) begin
            state <= ARB_GNT0;
            req_q <= make_req(p0_addr, p0_wdata, p0_read, p0_write);
          end else if (gnt[1]) begin
            state <= ARB_GNT1;
            req_q <= make_req(p1_addr, p1_wdata, p1_read, p1_write);
          end
        end
        ARB_GNT0: begin
          if (dfp_resp) begin
            state       <= ARB_IDLE;
            last_gnt    <= 1'b0;
            req_q.read  <= 1'b0;
            req_q.write <= 1'b0;
          end
        end
        ARB_GNT1: begin
          if (dfp_resp) begin
            state       <= ARB_IDLE;
            last_gnt    <= 1'b1;
            req_q.read  <= 1'b0;
            req_q.write <= 1'b0;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  // dfp_* come only from the request registers; the requesters may change
  // their inputs after the grant without disturbing the adapter.
  assign dfp_addr  = req_q.addr;
  assign dfp_wdata = req_q.wdata;
  assign dfp_read  = req_q.read;
  assign dfp_write = req_q.write;

  // Completion is routed combinationally in the dfp_resp cycle.
  assign p0_resp  = (state == ARB_GNT0) && dfp_resp;
  assign p1_resp  = (state == ARB_GNT1) && dfp_resp;
  assign p0_rdata = p0_resp ? dfp_rdata : '0;
  assign p1_rdata = p1_resp ? dfp_rdata : '0;

  assign dbg_state = state;

  p0_rw_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
    !(p0_read && p0_write));
  p1_rw_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
    !(p1_read && p1_write));

endmodule

// File: tb/tb_cacheline_arbiter.sv
module tb_cacheline_arbiter;
  import cache_arb_pkg::*;

  // index 0: round-robin instance, index 1: fixed-priority instance
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [31:0]  p0_addr [2];
  logic [31:0]  p1_addr [2];
  logic         p0_read [2];
  logic         p1_read [2];
  logic         p0_write [2];
  logic         p1_write [2];
  logic [255:0] p0_wdata [2];
  logic [255:0] p1_wdata [2];
  logic [255:0] p0_rdata [2];
  logic [255:0] p1_rdata [2];
  logic         p0_resp [2];
  logic         p1_resp [2];
  logic [31:0]  dfp_addr [2];
  logic         dfp_read [2];
  logic         dfp_write [2];
  logic [255:0] dfp_wdata [2];
  logic [255:0] dfp_rdata [2];
  logic         dfp_resp [2];
  arb_state_t   dbg_state [2];

  int vectors = 0;
  int miscompares = 0;
  logic [1:0] exp_q[$];

  always #5 clk = ~clk;

  cacheline_arbiter #(.FIXED_PRIO(0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .p0_addr(p0_addr[0]), .p0_read(p0_read[0]), .p0_write(p0_write[0]),
    .p0_wdata(p0_wdata[0]), .p0_rdata(p0_rdata[0]), .p0_resp(p0_resp[0]),
    .p1_addr(p1_addr[0]), .p1_read(p1_read[0]), .p1_write(p1_write[0]),
    .p1_wdata(p1_wdata[0]), .p1_rdata(p1_rdata[0]), .p1_resp(p1_resp[0]),
    .dfp_addr(dfp_addr[0]), .dfp_read(dfp_read[0]), .dfp_write(dfp_write[0]),
    .dfp_wdata(dfp_wdata[0]), .dfp_rdata(dfp_rdata[0]), .dfp_resp(dfp_resp[0]),
    .dbg_state(dbg_state[0])
  );

  cacheline_arbiter #(.FIXED_PRIO(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .p0_addr(p0_addr[1]), .p0_read(p0_read[1]), .p0_write(p0_write[1]),
    .p0_wdata(p0_wdata[1]), .p0_rdata(p0_rdata[1]), .p0_resp(p0_resp[1]),
    .p1_addr(p1_addr[1]), .p1_read(p1_read[1]), .p1_write(p1_write[1]),
    .p1_wdata(p1_wdata[1]), .p1_rdata(p1_rdata[1]), .p1_resp(p1_resp[1]),
    .dfp_addr(dfp_addr[1]), .dfp_read(dfp_read[1]), .dfp_write(dfp_write[1]),
    .dfp_wdata(dfp_wdata[1]), .dfp_rdata(dfp_rdata[1]), .dfp_resp(dfp_resp[1]),
    .dbg_state(dbg_state[1])
  );

  // ---------------- driver helpers ----------------
  function automatic logic [255:0] rand_line();
    return {$urandom(), $urandom(), $urandom(), $urandom(),
            $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic set_req(input int d, input int p, input logic rd, input logic wr,
                         input logic [31:0] a, input logic [255:0] w);
    if (p == 0) begin
      p0_read[d] = rd; p0_write[d] = wr; p0_addr[d] = a; p0_wdata[d] = w;
    end else begin
      p1_read[d] = rd; p1_write[d] = wr; p1_addr[d] = a; p1_wdata[d] = w;
    end
  endtask

  task automatic clear_inputs();
    for (int d = 0; d < 2; d++) begin
      set_req(d, 0, 1'b0, 1'b0, 32'h0, 256'h0);
      set_req(d, 1, 1'b0, 1'b0, 32'h0, 256'h0);
      dfp_resp[d] = 1'b0;
      dfp_rdata[d] = 256'h0;
    end
  endtask

  // Leaves the bench at a falling edge with reset released.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      vectors++;
      if ({dfp_read[d], dfp_write[d], dfp_addr[d], dfp_wdata[d]} !== 290'h0) begin
        miscompares++;
        $display("FAIL reset_dfp[%0d]: got r=%b w=%b a=%h, want all zero",
                 d, dfp_read[d], dfp_write[d], dfp_addr[d]);
      end
      vectors++;
      if ({p0_resp[d], p1_resp[d], p0_rdata[d], p1_rdata[d]} !== 514'h0) begin
        miscompares++;
        $display("FAIL reset_resp[%0d]: got resp=%b%b, want 00 and zero rdata",
                 d, p1_resp[d], p0_resp[d]);
      end
      vectors++;
      if (dbg_state[d] !== ARB_IDLE) begin
        miscompares++;
        $display("FAIL reset_state[%0d]: got %0d want %0d", d, dbg_state[d], ARB_IDLE);
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single_read();
    logic [255:0] a5;
    a5 = {32{8'hA5}};
    do_reset();
    set_req(0, 0, 1'b1, 1'b0, 32'h0000_1234, 256'h0);
    @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if ({dfp_read[0], dfp_write[0], dfp_addr[0]} !== {2'b10, 32'h0000_1234}) begin
        miscompares++;
        $display("FAIL single_dfp cyc%0d: got r=%b w=%b a=%h want r=1 w=0 a=00001234",
                 k, dfp_read[0], dfp_write[0], dfp_addr[0]);
      end
      if (k < 2) begin
        @(posedge clk);
        @(negedge clk);
      end
    end
    dfp_resp[0] = 1'b1;
    dfp_rdata[0] = a5;
    #1;
    vectors++;
    if ({p0_resp[0], p0_rdata[0], p1_resp[0], p1_rdata[0]} !== {1'b1, a5, 1'b0, 256'h0}) begin
      miscompares++;
      $display("FAIL single_resp: got p0_resp=%b p0_rdata=%h p1_resp=%b want 1/A5..A5/0",
               p0_resp[0], p0_rdata[0], p1_resp[0]);
    end
    @(posedge clk);
    @(negedge clk);
    dfp_resp[0] = 1'b0;
    set_req(0, 0, 1'b0, 1'b0, 32'h0, 256'h0);
    vectors++;
    if ({p0_resp[0], dfp_read[0], dfp_write[0]} !== 3'b000 || dbg_state[0] !== ARB_IDLE) begin
      miscompares++;
      $display("FAIL single_done: got resp=%b r=%b w=%b state=%0d want 0 0 0 IDLE",
               p0_resp[0], dfp_read[0], dfp_write[0], dbg_state[0]);
    end
  endtask

  task automatic test_simultaneous();
    logic [255:0] ones, rd;
    ones = {64{4'h1}};
    rd = rand_line();
    do_reset();
    set_req(0, 0, 1'b1, 1'b0, 32'h0000_0A00, 256'h0);
    set_req(0, 1, 1'b0, 1'b1, 32'h0000_0B00, ones);
    @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({dfp_read[0], dfp_write[0], dfp_addr[0]} !== {2'b10, 32'h0000_0A00}) begin
      miscompares++;
      $display("FAIL sim_first: got r=%b w=%b a=%h want port0 read a=00000a00",
               dfp_read[0], dfp_write[0], dfp_addr[0]);
    end
    dfp_resp[0] = 1'b1;
    dfp_rdata[0] = rd;
    #1;
    vectors++;
    if ({p0_resp[0], p0_rdata[0], p1_resp[0]} !== {1'b1, rd, 1'b0}) begin
      miscompares++;
      $display("FAIL sim_resp0: got p0_resp=%b p1_resp=%b want 1 0", p0_resp[0], p1_resp[0]);
    end
    @(posedge clk);
    @(negedge clk);  // resp + 1: idle, port 0 drops
    dfp_resp[0] = 1'b0;
    set_req(0, 0, 1'b0, 1'b0, 32'h0, 256'h0);
    vectors++;
    if ({dfp_read[0], dfp_write[0]} !== 2'b00) begin
      miscompares++;
      $display("FAIL sim_gap: got r=%b w=%b want 0 0", dfp_read[0], dfp_write[0]);
    end
    @(posedge clk);
    @(negedge clk);  // resp + 2: port 1 write on dfp
    vectors++;
    if ({dfp_read[0], dfp_write[0], dfp_addr[0], dfp_wdata[0]} !== {2'b01, 32'h0000_0B00, ones}) begin
      miscompares++;
      $display("FAIL sim_second: got r=%b w=%b a=%h wd=%h want write a=00000b00 wd=11..1",
               dfp_read[0], dfp_write[0], dfp_addr[0], dfp_wdata[0]);
    end
    dfp_resp[0] = 1'b1;
    #1;
    vectors++;
    if ({p1_resp[0], p0_resp[0], p0_rdata[0]} !== {2'b10, 256'h0}) begin
      miscompares++;
      $display("FAIL sim_resp1: got p1_resp=%b p0_resp=%b want 1 0", p1_resp[0], p0_resp[0]);
    end
    @(posedge clk);
    @(negedge clk);
    set_req(0, 1, 1'b0, 1'b0, 32'h0, 256'h0);
    // stray adapter response while idle must be ignored
    dfp_resp[0] = 1'b1;
    dfp_rdata[0] = rand_line();
    #1;
    vectors++;
    if ({p0_resp[0], p1_resp[0], p0_rdata[0], p1_rdata[0]} !== 514'h0) begin
      miscompares++;
      $display("FAIL stray_resp: got p0_resp=%b p1_resp=%b want 0 0", p0_resp[0], p1_resp[0]);
    end
    @(posedge clk);
    @(negedge clk);
    dfp_resp[0] = 1'b0;
    vectors++;
    if (dbg_state[0] !== ARB_IDLE) begin
      miscompares++;
      $display("FAIL stray_state: got %0d want IDLE", dbg_state[0]);
    end
  endtask

  // Both ports keep re-requesting; expected grant order comes from exp_q.
  task automatic test_starvation(input int d);
    int served, cyc;
    int drop[2];
    int rearm[2];
    int k[2];
    logic [1:0] port, want;
    do_reset();
    exp_q.delete();
    for (int i = 0; i < 6; i++) exp_q.push_back((d == 1) ? 2'(1 - (i % 2)) : 2'(i % 2));
    served = 0; cyc = 0;
    drop = '{0, 0}; rearm = '{0, 0}; k = '{0, 0};
    set_req(d, 0, 1'b1, 1'b0, 32'h100, 256'h0);
    set_req(d, 1, 1'b0, 1'b1, 32'h200, rand_line());
    while (served < 6 && cyc < 200) begin
      for (int p = 0; p < 2; p++) begin
        if (drop[p] != 0) begin
          drop[p] = 0; rearm[p] = 1;
          set_req(d, p, 1'b0, 1'b0, 32'h0, 256'h0);
        end else if (rearm[p] != 0) begin
          rearm[p] = 0; k[p]++;
          if (p == 0) set_req(d, 0, 1'b1, 1'b0, 32'h100 + k[0], 256'h0);
          else        set_req(d, 1, 1'b0, 1'b1, 32'h200 + k[1], rand_line());
        end
      end
      dfp_resp[d] = 1'b0;
      if (dfp_read[d] || dfp_write[d]) begin
        port = dfp_addr[d][9] ? 2'd1 : 2'd0;
        want = (exp_q.size() > 0) ? exp_q.pop_front() : 2'd3;
        vectors++;
        if (port !== want) begin
          miscompares++;
          $display("FAIL starve[%0d] txn%0d: granted port %0d want %0d", d, served, port, want);
        end
        dfp_resp[d] = 1'b1;
        dfp_rdata[d] = rand_line();
        drop[port] = 1;
        served++;
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    dfp_resp[d] = 1'b0;
    vectors++;
    if (served != 6 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL starve_done[%0d]: served %0d of 6, %0d left", d, served, exp_q.size());
    end
    clear_inputs();
  endtask

  // Random traffic against a transaction-level model of the arbiter.
  task automatic test_random(input int d, input int ntx);
    int pend[2];
    int gap[2];
    int drop[2];
    logic [31:0]  ra[2];
    logic [255:0] rw[2];
    logic         rr[2];
    int busy, owner, last, wait_cnt, done, cyc, fire;
    logic [31:0]  la;
    logic [255:0] lw, rd;
    logic         lr, lwr, wr_sel;
    logic [1:0]   reqv;
    logic [289:0] exp_dfp;
    do_reset();
    busy = 0; owner = 0; last = 1; wait_cnt = 0; done = 0; cyc = 0;
    la = 32'h0; lw = 256'h0; lr = 1'b0; lwr = 1'b0;
    for (int p = 0; p < 2; p++) begin
      pend[p] = 0; drop[p] = 0; gap[p] = $urandom_range(0, 2);
      ra[p] = 32'h0; rw[p] = 256'h0; rr[p] = 1'b0;
    end
    while (done < ntx && cyc < 5000) begin
      for (int p = 0; p < 2; p++) begin
        if (drop[p] != 0) begin
          drop[p] = 0; pend[p] = 0; gap[p] = $urandom_range(0, 2);
          set_req(d, p, 1'b0, 1'b0, ra[p], rw[p]);
        end else if (pend[p] == 0) begin
          if (gap[p] == 0) begin
            wr_sel = 1'($urandom_range(0, 1));
            ra[p] = $urandom(); rw[p] = rand_line(); rr[p] = ~wr_sel;
            pend[p] = 1;
            set_req(d, p, ~wr_sel, wr_sel, ra[p], rw[p]);
          end else begin
            gap[p]--;
          end
        end else if (busy != 0 && owner == p && $urandom_range(0, 1) == 1) begin
          // requester changes addr/data after its grant; dfp must not follow
          set_req(d, p, rr[p], ~rr[p], $urandom(), rand_line());
        end
      end
      exp_dfp = {(busy != 0) & lr, (busy != 0) & lwr, la, lw};
      vectors++;
      if ({dfp_read[d], dfp_write[d], dfp_addr[d], dfp_wdata[d]} !== exp_dfp) begin
        miscompares++;
        $display("FAIL rand_dfp[%0d] cyc%0d: got r=%b w=%b a=%h want r=%b w=%b a=%h",
                 d, cyc, dfp_read[d], dfp_write[d], dfp_addr[d],
                 exp_dfp[289], exp_dfp[288], exp_dfp[287:256]);
      end
      fire = (busy != 0 && wait_cnt == 0) ? 1 : 0;
      rd = rand_line();
      dfp_rdata[d] = rd;
      if (fire != 0) dfp_resp[d] = 1'b1;
      else begin
        dfp_resp[d] = (busy == 0) && ($urandom_range(0, 5) == 0);
        if (busy != 0) wait_cnt--;
      end
      #1;
      vectors++;
      if ({p0_resp[d], p0_rdata[d], p1_resp[d], p1_rdata[d]} !==
          {fire != 0 && owner == 0, (fire != 0 && owner == 0) ? rd : 256'h0,
           fire != 0 && owner == 1, (fire != 0 && owner == 1) ? rd : 256'h0}) begin
        miscompares++;
        $display("FAIL rand_resp[%0d] cyc%0d: got p0_resp=%b p1_resp=%b want fire=%0d owner=%0d",
                 d, cyc, p0_resp[d], p1_resp[d], fire, owner);
      end
      if (fire != 0) begin
        busy = 0; last = owner; drop[owner] = 1; done++;
      end else if (busy == 0) begin
        reqv = {pend[1] != 0, pend[0] != 0};
        if (reqv != 2'b00) begin
          if (reqv == 2'b11) owner = (d == 1) ? 1 : 1 - last;
          else owner = reqv[1] ? 1 : 0;
          busy = 1;
          la = ra[owner]; lw = rw[owner]; lr = rr[owner]; lwr = ~rr[owner];
          wait_cnt = $urandom_range(0, 3);
        end
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    vectors++;
    if (done != ntx) begin
      miscompares++;
      $display("FAIL rand_timeout[%0d]: completed %0d of %0d", d, done, ntx);
    end
    clear_inputs();
  endtask

  task automatic test_reset_mid();
    do_reset();
    // complete one port-0 transaction so the tie pointer moves off reset value
    set_req(0, 0, 1'b1, 1'b0, 32'h0000_0C00, 256'h0);
    @(posedge clk);
    @(negedge clk);
    dfp_resp[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    dfp_resp[0] = 1'b0;
    set_req(0, 0, 1'b0, 1'b0, 32'h0, 256'h0);
    set_req(0, 1, 1'b1, 1'b0, 32'h0000_0D00, 256'h0);
    @(posedge clk);
    @(negedge clk);
    vectors++;
    if (dbg_state[0] !== ARB_GNT1 || dfp_read[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_grant: got state=%0d r=%b want GNT1 1", dbg_state[0], dfp_read[0]);
    end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({dfp_read[0], dfp_write[0], dfp_addr[0], dfp_wdata[0], p0_resp[0], p1_resp[0]} !== 292'h0
        || dbg_state[0] !== ARB_IDLE) begin
      miscompares++;
      $display("FAIL mid_async: got r=%b a=%h state=%0d want all zero IDLE",
               dfp_read[0], dfp_addr[0], dbg_state[0]);
    end
    clear_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    set_req(0, 0, 1'b1, 1'b0, 32'h0000_0E00, 256'h0);
    set_req(0, 1, 1'b1, 1'b0, 32'h0000_0F00, 256'h0);
    @(posedge clk);
    @(negedge clk);
    vectors++;
    if ({dfp_read[0], dfp_addr[0]} !== {1'b1, 32'h0000_0E00}) begin
      miscompares++;
      $display("FAIL mid_tie: got r=%b a=%h want 1 00000e00", dfp_read[0], dfp_addr[0]);
    end
    clear_inputs();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_single_read();
    test_simultaneous();
    test_starvation(0);
    test_starvation(1);
    test_random(0, 60);
    test_random(1, 60);
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
